// File: rtl/ctrl_sequencer.sv
// Accumulator-CPU control sequencer: FETCH/EXEC1/EXEC2/SHIFT/HALT state machine with strobe decode.
// Strobes are combinational from registered state, opcode, shift amount and flags; run stalls only in FETCH.
module ctrl_sequencer #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [3:0]         C,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flag_n,
  input  logic               flag_z,
  output logic [2:0]         Q,
  output logic               irload,
  output logic               pcinc,
  output logic               pcload,
  output logic               MUX1sel,
  output logic               memwrite,
  output logic               accen,
  output logic               MUX3sel,
  output logic               addsub,
  output logic               accshift,
  output logic               shiftdir,
  output logic               halted,
  output logic               illegal
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC1 = 3'd1;
  localparam logic [2:0] S_EXEC2 = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JMI = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  logic [2:0]         state, state_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic               dir, dir_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    Q         = 3'b000;
    irload    = 1'b0;
    pcinc     = 1'b0;
    pcload    = 1'b0;
    MUX1sel   = 1'b0;
    memwrite  = 1'b0;
    accen     = 1'b0;
    MUX3sel   = 1'b0;
    addsub    = 1'b0;
    accshift  = 1'b0;
    shiftdir  = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        Q = 3'b100;
        if (run) begin
          irload    = 1'b1;
          pcinc     = 1'b1;
          state_nxt = S_EXEC1;
        end
      end

      S_EXEC1: begin
        Q         = 3'b001;
        state_nxt = S_FETCH;
        case (C)
          OP_LDA, OP_ADD, OP_SUB: begin
            MUX1sel   = 1'b1;
            state_nxt = S_EXEC2;
          end
          OP_STA: begin
            MUX1sel  = 1'b1;
            memwrite = 1'b1;
          end
          OP_JMP: pcload = 1'b1;
          OP_JMI: pcload = flag_n;
          OP_JEQ: pcload = flag_z;
          OP_LDI: accen  = 1'b1;
          OP_STP: state_nxt = S_HALT;
          OP_LSL, OP_LSR: begin
            // First shift happens here; cnt holds the shifts still owed after this cycle.
            if (shamt != CNT_ZERO) begin
              accen    = 1'b1;
              accshift = 1'b1;
              shiftdir = (C == OP_LSR);
              dir_nxt  = (C == OP_LSR);
              cnt_nxt  = shamt - CNT_ONE;
              if (shamt > CNT_ONE) state_nxt = S_SHIFT;
            end
          end
          default: illegal = 1'b1;
        endcase
      end

      S_EXEC2: begin
        Q       = 3'b010;
        MUX1sel = 1'b1;
        accen   = 1'b1;
        if (C == OP_ADD) begin
          MUX3sel = 1'b1;
          addsub  = 1'b1;
        end else if (C == OP_SUB) begin
          MUX3sel = 1'b1;
        end
        state_nxt = S_FETCH;
      end

      S_SHIFT: begin
        Q        = 3'b001;
        accen    = 1'b1;
        accshift = 1'b1;
        shiftdir = dir;
        if (cnt != CNT_ZERO) cnt_nxt = cnt - CNT_ONE;
        if (cnt <= CNT_ONE) state_nxt = S_FETCH;
      end

      S_HALT: begin
        Q      = 3'b000;
        halted = 1'b1;
      end

      default: state_nxt = S_FETCH;
    endcase

    // State is already FETCH during reset; this keeps a high run from leaking a fetch strobe.
    if (!rst_n) begin
      Q        = 3'b100;
      irload   = 1'b0;
      pcinc    = 1'b0;
      pcload   = 1'b0;
      MUX1sel  = 1'b0;
      memwrite = 1'b0;
      accen    = 1'b0;
      MUX3sel  = 1'b0;
      addsub   = 1'b0;
      accshift = 1'b0;
      shiftdir = 1'b0;
      halted   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle Q and strobe-vector checks against hand-computed values.
module tb_ctrl_sequencer;
  localparam int DATA_W  = 16;
  localparam int SHAMT_W = $clog2(DATA_W);

  logic               clk = 1'b0;
  logic               rst_n, run, flag_n, flag_z;
  logic [3:0]         C;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]         Q;
  logic irload, pcinc, pcload, MUX1sel, memwrite, accen, MUX3sel, addsub;
  logic accshift, shiftdir, halted, illegal;

  int errors = 0;
  int checks = 0;

  // Strobe vector: irload pcinc pcload MUX1sel memwrite accen MUX3sel addsub accshift shiftdir halted illegal
  localparam logic [11:0] S_NONE  = 12'h000;
  localparam logic [11:0] S_FETCH = 12'hC00;
  localparam logic [11:0] S_MEMRD = 12'h100;
  localparam logic [11:0] S_STA   = 12'h180;
  localparam logic [11:0] S_PCLD  = 12'h200;
  localparam logic [11:0] S_LDI   = 12'h040;
  localparam logic [11:0] S_ADD2  = 12'h170;
  localparam logic [11:0] S_SUB2  = 12'h160;
  localparam logic [11:0] S_LDA2  = 12'h140;
  localparam logic [11:0] S_SHR   = 12'h04C;
  localparam logic [11:0] S_SHL   = 12'h048;
  localparam logic [11:0] S_HALT  = 12'h002;
  localparam logic [11:0] S_ILL   = 12'h001;

  wire [11:0] strobes = {irload, pcinc, pcload, MUX1sel, memwrite, accen,
                         MUX3sel, addsub, accshift, shiftdir, halted, illegal};

  ctrl_sequencer #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .C(C), .shamt(shamt),
    .flag_n(flag_n), .flag_z(flag_z), .Q(Q),
    .irload(irload), .pcinc(pcinc), .pcload(pcload), .MUX1sel(MUX1sel),
    .memwrite(memwrite), .accen(accen), .MUX3sel(MUX3sel), .addsub(addsub),
    .accshift(accshift), .shiftdir(shiftdir), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] exp_q, input logic [11:0] exp_s);
    checks++;
    assert ({Q, strobes} === {exp_q, exp_s}) else begin
      errors++;
      $error("FAIL %s: observed Q=%b strobes=%h, expected Q=%b strobes=%h", tag, Q, strobes, exp_q, exp_s);
    end
  endtask

  // Check the current cycle, then advance to 1 time unit past the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] exp_q, input logic [11:0] exp_s);
    #1;
    check(tag, exp_q, exp_s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; C = 4'h0; shamt = '0; flag_n = 1'b0; flag_z = 1'b0;
    #2;
    check("reset_hold", 3'b100, S_NONE);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    C = 4'h2;
    cyc("add_fetch", 3'b100, S_FETCH);
    cyc("add_exec1", 3'b001, S_MEMRD);
    cyc("add_exec2", 3'b010, S_ADD2);
    C = 4'h3;
    cyc("sub_fetch", 3'b100, S_FETCH);
    cyc("sub_exec1", 3'b001, S_MEMRD);
    cyc("sub_exec2", 3'b010, S_SUB2);

    C = 4'h5; flag_n = 1'b0;
    cyc("jmi_n0_fetch", 3'b100, S_FETCH);
    cyc("jmi_n0_exec1", 3'b001, S_NONE);
    flag_n = 1'b1;
    cyc("jmi_n1_fetch", 3'b100, S_FETCH);
    cyc("jmi_n1_exec1", 3'b001, S_PCLD);
    flag_n = 1'b0;

    C = 4'h6; flag_z = 1'b0;
    #1; check("jeq_fetch_z0", 3'b100, S_FETCH);
    flag_z = 1'b1;
    cyc("jeq_fetch_z1", 3'b100, S_FETCH);
    cyc("jeq_exec1", 3'b001, S_PCLD);
    flag_z = 1'b0;

    C = 4'hA; shamt = 4'd5;
    cyc("lsr5_fetch", 3'b100, S_FETCH);
    for (int i = 0; i < 5; i++) cyc($sformatf("lsr5_shift%0d", i), 3'b001, S_SHR);
    shamt = 4'd0;
    cyc("lsr0_fetch", 3'b100, S_FETCH);
    cyc("lsr0_exec1", 3'b001, S_NONE);

    C = 4'h9; shamt = 4'd15;
    cyc("lsl15_fetch", 3'b100, S_FETCH);
    for (int i = 0; i < 6; i++) cyc($sformatf("lsl15_shift%0d", i), 3'b001, S_SHL);
    #1; check("lsl15_shift6", 3'b001, S_SHL);
    rst_n = 1'b0;
    #1; check("lsl15_reset", 3'b100, S_NONE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    C = 4'h8; shamt = 4'd0;
    cyc("ldi_fetch", 3'b100, S_FETCH);
    cyc("ldi_exec1", 3'b001, S_LDI);

    run = 1'b0;
    for (int i = 0; i < 4; i++) cyc($sformatf("run0_hold%0d", i), 3'b100, S_NONE);
    run = 1'b1;
    cyc("run1_fetch", 3'b100, S_FETCH);
    cyc("run1_ldi", 3'b001, S_LDI);

    run = 1'b0; C = 4'h1;
    #1; run = 1'b1;
    cyc("sta_fetch", 3'b100, S_FETCH);
    run = 1'b0;
    cyc("sta_exec1", 3'b001, S_STA);
    run = 1'b1; C = 4'h0;
    cyc("lda_fetch", 3'b100, S_FETCH);
    run = 1'b0;
    cyc("lda_exec1", 3'b001, S_MEMRD);
    cyc("lda_exec2", 3'b010, S_LDA2);
    run = 1'b1; C = 4'h4;
    cyc("jmp_fetch", 3'b100, S_FETCH);
    cyc("jmp_exec1", 3'b001, S_PCLD);

    C = 4'hB;
    cyc("ill_b_fetch", 3'b100, S_FETCH);
    run = 1'b0;
    cyc("ill_b_exec1", 3'b001, S_ILL);
    cyc("ill_b_after", 3'b100, S_NONE);
    run = 1'b1; C = 4'hF;
    cyc("ill_f_fetch", 3'b100, S_FETCH);
    cyc("ill_f_exec1", 3'b001, S_ILL);

    C = 4'h7;
    cyc("stp_fetch", 3'b100, S_FETCH);
    cyc("stp_exec1", 3'b001, S_NONE);
    for (int i = 0; i < 20; i++) begin
      flag_n = i[0]; flag_z = i[1];
      C = (i < 10) ? 4'h2 : 4'h9;
      shamt = 4'd3;
      cyc($sformatf("halt%0d", i), 3'b000, S_HALT);
    end
    rst_n = 1'b0;
    #1; check("halt_reset", 3'b100, S_NONE);
    @(posedge clk); #1;
    rst_n = 1'b1; C = 4'h8;
    cyc("post_halt_fetch", 3'b100, S_FETCH);
    cyc("post_halt_ldi", 3'b001, S_LDI);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
